// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//   Safety stage behind the 4-way light controller. It registers the controller's
//   approach codes onto the lamps and checks every cycle for illegal codes,
//   conflicting non-red approaches and illegal phase sequences. Any violation
//   latches a fault and forces all lamps red until a qualified clear completes.
// Ports:
//   clk            system clock, rising-edge
//   rst            asynchronous active-low reset
//   r1..r4         controller approach codes (00 red, 01 yellow, 10 green, 11 illegal)
//   fault_clr      clear request, only acted on while faulted
//   lamp1..lamp4   registered lamp drive, same encoding as r1..r4
//   fault          high while faulted or recovering
//   fault_code     latched cause (0 none, 1 illegal, 2 conflict, 3 skip yellow,
//                  4 short yellow, 5 bad sequence)
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned CLR_HOLD   = 4,
  parameter int unsigned CW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] r1,
  input  logic [1:0] r2,
  input  logic [1:0] r3,
  input  logic [1:0] r4,
  input  logic       fault_clr,
  output logic [1:0] lamp1,
  output logic [1:0] lamp2,
  output logic [1:0] lamp3,
  output logic [1:0] lamp4,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned NA = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_NORMAL, ST_FAULT, ST_RECOVER} state_e;

  state_e        state_q, state_d;
  logic [1:0]    r_c      [NA];
  logic [1:0]    prev_q   [NA];
  logic [1:0]    prev_d   [NA];
  logic [CW-1:0] ycnt_q   [NA];
  logic [CW-1:0] ycnt_d   [NA];
  logic [1:0]    lamp_q   [NA];
  logic [1:0]    lamp_d   [NA];
  logic [CW-1:0] hold_q, hold_d, hold_inc_c;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    viol_code_c;
  logic          all_red_c;

  assign r_c[0] = r1;
  assign r_c[1] = r2;
  assign r_c[2] = r3;
  assign r_c[3] = r4;

  assign lamp1      = lamp_q[0];
  assign lamp2      = lamp_q[1];
  assign lamp3      = lamp_q[2];
  assign lamp4      = lamp_q[3];
  assign fault      = fault_q;
  assign fault_code = code_q;

  // Violation detection on current inputs; lowest code wins.
  always_comb begin
    logic       ill, skip, shrt, bad;
    logic [2:0] nonred;
    ill       = 1'b0;
    skip      = 1'b0;
    shrt      = 1'b0;
    bad       = 1'b0;
    nonred    = 3'd0;
    all_red_c = 1'b1;
    for (int i = 0; i < NA; i++) begin
      if (r_c[i] != 2'b00) all_red_c = 1'b0;
      if (r_c[i] == 2'b11) ill = 1'b1;
      if ((r_c[i] == 2'b01) || (r_c[i] == 2'b10)) nonred = nonred + 3'd1;
      if ((prev_q[i] == 2'b10) && (r_c[i] == 2'b00)) skip = 1'b1;
      if ((prev_q[i] == 2'b01) && (r_c[i] != 2'b01) && (ycnt_q[i] < CW'(MIN_YELLOW)))
        shrt = 1'b1;
      if (((prev_q[i] == 2'b00) && (r_c[i] == 2'b01)) ||
          ((prev_q[i] == 2'b01) && (r_c[i] == 2'b10)))
        bad = 1'b1;
    end
    if (ill)              viol_code_c = 3'd1;
    else if (nonred > 3'd1) viol_code_c = 3'd2;
    else if (skip)        viol_code_c = 3'd3;
    else if (shrt)        viol_code_c = 3'd4;
    else if (bad)         viol_code_c = 3'd5;
    else                  viol_code_c = 3'd0;
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    code_d     = code_q;
    hold_d     = hold_q;
    hold_inc_c = (hold_q == CNT_MAX) ? hold_q : hold_q + CW'(1);
    for (int i = 0; i < NA; i++) begin
      lamp_d[i] = 2'b00;
      prev_d[i] = r_c[i];
      if (r_c[i] == 2'b01) ycnt_d[i] = (ycnt_q[i] == CNT_MAX) ? ycnt_q[i] : ycnt_q[i] + CW'(1);
      else                 ycnt_d[i] = '0;
    end
    unique case (state_q)
      ST_NORMAL: begin
        if (viol_code_c != 3'd0) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = viol_code_c;
        end else begin
          for (int i = 0; i < NA; i++) lamp_d[i] = r_c[i];
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_RECOVER;
          hold_d  = '0;
        end
      end
      ST_RECOVER: begin
        if (all_red_c) begin
          hold_d = hold_inc_c;
          if (hold_inc_c >= CW'(CLR_HOLD)) begin
            state_d = ST_NORMAL;
            fault_d = 1'b0;
            code_d  = 3'd0;
          end
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_NORMAL;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      hold_q  <= '0;
      for (int i = 0; i < NA; i++) begin
        lamp_q[i] <= 2'b00;
        prev_q[i] <= 2'b00;
        ycnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
      for (int i = 0; i < NA; i++) begin
        lamp_q[i] <= lamp_d[i];
        prev_q[i] <= prev_d[i];
        ycnt_q[i] <= ycnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: directed scenarios plus a
// randomized run, all compared against a rule-level reference model.
module tb_traffic_conflict_monitor;

  localparam int MIN_Y = 2;
  localparam int HOLD  = 4;
  localparam int SAT   = 15;

  logic       clk;
  logic       rst;
  logic [1:0] rin [4];
  logic       fault_clr;
  logic [1:0] lamp1, lamp2, lamp3, lamp4;
  logic       fault;
  logic [2:0] fault_code;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 normal, 1 faulted, 2 recovering.
  int m_mode;
  int m_prev [4];
  int m_yrun [4];
  int m_hold;
  int e_lamp [4];
  int e_fault;
  int e_code;

  traffic_conflict_monitor #(.MIN_YELLOW(2), .CLR_HOLD(4), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .r1(rin[0]), .r2(rin[1]), .r3(rin[2]), .r4(rin[3]),
    .fault_clr(fault_clr),
    .lamp1(lamp1), .lamp2(lamp2), .lamp3(lamp3), .lamp4(lamp4),
    .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [11:0] obs_vec = {lamp1, lamp2, lamp3, lamp4, fault, fault_code};

  function automatic logic [11:0] exp_vec();
    return {2'(e_lamp[0]), 2'(e_lamp[1]), 2'(e_lamp[2]), 2'(e_lamp[3]),
            1'(e_fault), 3'(e_code)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hold = 0; e_fault = 0; e_code = 0;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0; m_yrun[i] = 0; e_lamp[i] = 0;
    end
  endtask

  // Cause of a violation from the lamp rules: legal moves are hold, red->green,
  // green->yellow, yellow->red after at least MIN_Y yellow cycles.
  function automatic int model_code();
    int  nonred = 0;
    bit  ill = 0, skip = 0, shrt = 0, bad = 0;
    for (int i = 0; i < 4; i++) begin
      int v, p;
      v = int'(rin[i]);
      p = m_prev[i];
      if (v == 3) ill = 1;
      if (v == 1 || v == 2) nonred++;
      if (p == 2 && v == 0) skip = 1;
      if (p == 1 && v != 1 && m_yrun[i] < MIN_Y) shrt = 1;
      if ((p == 0 && v == 1) || (p == 1 && v == 2)) bad = 1;
    end
    if (ill) return 1;
    if (nonred > 1) return 2;
    if (skip) return 3;
    if (shrt) return 4;
    if (bad) return 5;
    return 0;
  endfunction

  // One clock: advance the model on the pre-edge inputs, settle 1 time unit after.
  task automatic tick();
    int  c;
    bit  all_red;
    c = model_code();
    all_red = (rin[0] == 0) && (rin[1] == 0) && (rin[2] == 0) && (rin[3] == 0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) e_lamp[i] = 0;
    if (m_mode == 0) begin
      if (c != 0) begin m_mode = 1; e_fault = 1; e_code = c; end
      else for (int i = 0; i < 4; i++) e_lamp[i] = int'(rin[i]);
    end else if (m_mode == 1) begin
      if (fault_clr) begin m_mode = 2; m_hold = 0; end
    end else begin
      if (all_red) begin
        m_hold = (m_hold < SAT) ? m_hold + 1 : SAT;
        if (m_hold >= HOLD) begin m_mode = 0; e_fault = 0; e_code = 0; end
      end else m_hold = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_yrun[i] = (rin[i] == 2'b01) ? ((m_yrun[i] < SAT) ? m_yrun[i] + 1 : SAT) : 0;
      m_prev[i] = int'(rin[i]);
    end
    #1;
  endtask

  task automatic set_all(input logic [1:0] a, b, c, d);
    rin[0] = a; rin[1] = b; rin[2] = c; rin[3] = d;
  endtask

  // Get back to NORMAL with all history red: force a fault, clear, hold red.
  task automatic back_to_normal();
    set_all(2'b00, 2'b00, 2'b00, 2'b11); fault_clr = 1'b0; tick();
    set_all(2'b00, 2'b00, 2'b00, 2'b00); fault_clr = 1'b1; tick();
    fault_clr = 1'b0;
    for (int i = 0; i < HOLD; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; fault_clr = 1'b0;
    set_all(2'b00, 2'b00, 2'b00, 2'b00);
    model_reset();
    #2;
    checks++;
    if (obs_vec !== 12'h000) begin
      errors++; $display("FAIL reset got=%h exp=%h", obs_vec, 12'h000);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_legal_seq();
    logic [1:0] seq [10];
    logic [1:0] last;
    seq[0] = 2'b00;
    for (int i = 1; i <= 5; i++) seq[i] = 2'b10;
    for (int i = 6; i <= 8; i++) seq[i] = 2'b01;
    seq[9] = 2'b00;
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < 10; k++) begin
        set_all(2'b00, 2'b00, 2'b00, 2'b00);
        rin[a] = seq[k];
        last = seq[k];
        tick();
        checks++;
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL legal_seq a=%0d k=%0d got=%h exp=%h", a, k, obs_vec, exp_vec());
        end
        checks++;
        if (((a == 0) ? lamp1 : lamp2) !== last || fault !== 1'b0) begin
          errors++; $display("FAIL legal_passthru a=%0d k=%0d lamp1=%b lamp2=%b fault=%b exp_lamp=%b",
                             a, k, lamp1, lamp2, fault, last);
        end
      end
    end
  endtask

  task automatic test_conflict();
    back_to_normal();
    set_all(2'b10, 2'b10, 2'b00, 2'b00);
    tick();
    checks++;
    if (obs_vec !== {8'h00, 1'b1, 3'd2}) begin
      errors++; $display("FAIL conflict got=%h exp=%h", obs_vec, {8'h00, 1'b1, 3'd2});
    end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) rin[i] = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs_vec !== {8'h00, 1'b1, 3'd2} || obs_vec !== exp_vec()) begin
        errors++; $display("FAIL conflict_hold k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_skip_and_short();
    back_to_normal();
    set_all(2'b00, 2'b00, 2'b10, 2'b00); tick();
    set_all(2'b00, 2'b00, 2'b00, 2'b00); tick();
    checks++;
    if (fault_code !== 3'd3 || fault !== 1'b1) begin
      errors++; $display("FAIL skip_yellow code=%0d fault=%b exp_code=3", fault_code, fault);
    end
    back_to_normal();
    set_all(2'b10, 2'b00, 2'b00, 2'b00); tick();
    set_all(2'b01, 2'b00, 2'b00, 2'b00); tick();
    set_all(2'b00, 2'b00, 2'b00, 2'b00); tick();
    checks++;
    if (fault_code !== 3'd4 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL short_yellow got=%h exp=%h code=%0d exp_code=4", obs_vec, exp_vec(), fault_code);
    end
  endtask

  task automatic test_priority_and_badseq();
    back_to_normal();
    set_all(2'b10, 2'b10, 2'b00, 2'b11);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (obs_vec !== {8'h00, 1'b1, 3'd1}) begin
      errors++; $display("FAIL priority got=%h exp=%h", obs_vec, {8'h00, 1'b1, 3'd1});
    end
    // The simultaneous clear was not honoured: red inputs must not recover.
    set_all(2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < HOLD + 1; k++) tick();
    checks++;
    if (fault !== 1'b1 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL viol_beats_clr got=%h exp=%h", obs_vec, exp_vec());
    end
    back_to_normal();
    set_all(2'b00, 2'b01, 2'b00, 2'b00); tick();
    checks++;
    if (fault_code !== 3'd5 || fault !== 1'b1) begin
      errors++; $display("FAIL bad_seq code=%0d fault=%b exp_code=5", fault_code, fault);
    end
  endtask

  task automatic test_recovery();
    // Starts in FAULT with code 5 from the previous scenario.
    set_all(2'b00, 2'b00, 2'b00, 2'b00);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rin[0] = 2'b10; tick();
    checks++;
    if (fault !== 1'b1 || lamp1 !== 2'b00) begin
      errors++; $display("FAIL recover_glitch fault=%b lamp1=%b exp fault=1 lamp1=00", fault, lamp1);
    end
    rin[0] = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (fault !== ((k == 4) ? 1'b0 : 1'b1) || obs_vec !== exp_vec()) begin
        errors++; $display("FAIL recover_edge k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
      end
    end
    checks++;
    if (fault_code !== 3'd0) begin
      errors++; $display("FAIL recover_code got=%0d exp=0", fault_code);
    end
    rin[0] = 2'b10; tick();
    checks++;
    if (lamp1 !== 2'b10 || fault !== 1'b0) begin
      errors++; $display("FAIL recover_resume lamp1=%b fault=%b exp lamp1=10 fault=0", lamp1, fault);
    end
  endtask

  task automatic test_async_reset();
    back_to_normal();
    set_all(2'b10, 2'b10, 2'b00, 2'b00); tick();
    set_all(2'b00, 2'b00, 2'b00, 2'b00);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    tick(); tick();
    #3 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec !== 12'h000) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs_vec, 12'h000);
    end
    #2 rst = 1'b1;
    rin[0] = 2'b10; tick();
    checks++;
    if (lamp1 !== 2'b10 || fault !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL post_reset_green got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int sel;
    back_to_normal();
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) set_all(2'b00, 2'b00, 2'b00, 2'b00);
      else if (sel >= 7) rin[$urandom_range(0, 3)] = 2'($urandom_range(0, 3));
      fault_clr = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
      end
    end
    fault_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal_seq();
    test_conflict();
    test_skip_and_short();
    test_priority_and_badseq();
    test_recovery();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Safety stage directly downstream of traffic_light_4way. It consumes the four 2-bit approach signals r1..r4 and drives the physical lamp outputs.
- Passes the controller outputs through with one register of latency while checking every cycle for conflicting greens, illegal codes and illegal phase sequences.
- On any violation it latches a fault, forces all lamps red, and holds them red until a qualified clear sequence completes.

Parameters:
- MIN_YELLOW, 2: minimum consecutive cycles an approach must remain yellow.
- CLR_HOLD, 4: consecutive all-red input cycles required in RECOVER before returning to NORMAL.
- CW, 4: width of the yellow and hold counters. Both counters saturate at 2^CW-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- r1, r2, r3, r4  in  2 each  controller approach states: 00 red, 01 yellow, 10 green, 11 illegal.
- fault_clr  in  1  single-cycle clear request; honoured only in FAULT.
- lamp1, lamp2, lamp3, lamp4  out  2 each  registered lamp drive, same encoding as the inputs.
- fault  out  1  high while in FAULT or RECOVER.
- fault_code  out  3  latched cause; 0 = none.

Behaviour:
- Reset (rst low, async): state NORMAL; lamp1..4 = 00; fault = 0; fault_code = 0; prev1..4 = 00; yellow and hold counters = 0.
- prevN registers rN every cycle in every state. ycntN counts consecutive cycles with rN = 01, saturating; it clears when rN != 01.
- Legal per-approach transitions (cur vs prevN): hold, 00->10, 10->01, 01->00. Immediately after reset, 00->10 is therefore legal.
- Detection is combinational on current inputs. Codes, with lowest number winning when several occur in the same cycle:
  - 1 ILLEGAL: any rN = 11.
  - 2 CONFLICT: more than one approach non-red (01 or 10).
  - 3 SKIP_YELLOW: prevN = 10 and rN = 00.
  - 4 SHORT_YELLOW: prevN = 01, rN != 01, and ycntN < MIN_YELLOW.
  - 5 BAD_SEQ: 00->01 or 01->10.
- NORMAL:
  - No violation: lampN <= rN (1-cycle latency).
  - Violation: at that same edge, lamps <= 00, fault <= 1, fault_code <= winning code, state <= FAULT. The offending value never reaches the lamps.
- FAULT:
  - Lamps held 00; further violations ignored; fault_code retained.
  - fault_clr = 1 moves to RECOVER next edge, with the hold counter cleared.
- RECOVER:
  - Lamps held 00; fault stays 1.
  - Hold counter increments on each edge where all rN = 00, and resets to 0 when any rN != 00.
  - On the edge where the count reaches CLR_HOLD: state NORMAL, fault <= 0, fault_code <= 0, lamps <= 00 for that edge.
  - Pass-through resumes the following cycle. Detection resumes using the continuously tracked prevN.
- fault_clr is ignored in NORMAL and RECOVER. Holding fault_clr high in FAULT behaves like a single pulse.
- Reset asserted in any state, including mid-RECOVER, takes effect asynchronously to the reset values above.
- Simultaneous violation in NORMAL and fault_clr: the violation wins; fault_clr is ignored.

Test Plan:
- Legal sequence: r1 00->10 for 5 cycles, 01 for 3 cycles, 00; then the same on r2. Required: lamp1/lamp2 equal r1/r2 delayed one clk; fault = 0 throughout.
- r1 = 10 and r2 = 10 in the same cycle. Required: at that edge lamp1..4 = 00, fault = 1, fault_code = 2; values hold for 20 cycles with arbitrary inputs.
- r3 goes 10->00 directly. Required: fault_code = 3. Separately, with MIN_YELLOW = 2, r1 yellow for 1 cycle then 00. Required: fault_code = 4.
- In one cycle r4 = 11, r1 = 10, r2 = 10. Required: fault_code = 1 (priority). Separately, r2 goes 00->01. Required: fault_code = 5.
- Recovery: from FAULT, pulse fault_clr; inputs all 00 for 3 cycles, r1 = 10 for 1 cycle, then all 00. Required: fault drops exactly on the 4th all-red edge after the r1 glitch, fault_code = 0, and the next r1 = 10 appears on lamp1 one cycle later.
- Drive rst low asynchronously mid-RECOVER, between clock edges. Required: fault = 0, fault_code = 0, lamps = 00 immediately. After release, 00->10 on r1 is accepted without fault.
